// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: bus widths, the execute-stage
// `through` field layout, access-size encodings and FSM state encoding.
package mem_stage_pkg;

  localparam int EXE_BUS_W = 80;
  localparam int WB_BUS_W  = 38;

  typedef enum logic [1:0] {
    SZ_BYTE     = 2'b00,
    SZ_HALF     = 2'b01,
    SZ_WORD     = 2'b10,
    SZ_WORD_ALT = 2'b11
  } size_e;

  // Bit layout of through[15:0], MSB first.
  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    size_e      size;
    logic       signed_load;
    logic       reg_write;
    logic [4:0] dest;
    logic [4:0] rsvd;
  } through_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: store byte enables and data replication,
// misalignment detection, and load lane extraction with extension.
module mem_align
  import mem_stage_pkg::*;
(
  input  size_e       st_size,
  input  logic [1:0]  st_addr,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  output logic        misaligned,
  input  size_e       ld_size,
  input  logic [1:0]  ld_addr,
  input  logic        ld_signed,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [31:0] ld_shifted;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    st_be      = 4'b1111;
    st_wdata   = st_data;
    misaligned = 1'b0;
    unique case (st_size)
      SZ_BYTE: begin
        st_be    = 4'b0001 << st_addr;
        st_wdata = {4{st_data[7:0]}};
      end
      SZ_HALF: begin
        st_be      = 4'b0011 << st_addr;
        st_wdata   = {2{st_data[15:0]}};
        misaligned = st_addr[0];
      end
      default: misaligned = |st_addr;
    endcase
  end

  // Bring the addressed lane down to bit 0 before extending.
  assign ld_shifted = ld_rdata >> {ld_addr, 3'b000};

  always_comb begin
    ld_data = ld_shifted;
    unique case (ld_size)
      SZ_BYTE: ld_data = {{24{ld_signed & ld_shifted[7]}}, ld_shifted[7:0]};
      SZ_HALF: ld_data = {{16{ld_signed & ld_shifted[15]}}, ld_shifted[15:0]};
      default: ld_data = ld_shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: issues loads/stores over a req/ack port, stalls
// upstream while an access is outstanding and emits a registered WB bus.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [EXE_BUS_W-1:0] EXE_MEM_BUS,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [29:0]          dmem_addr,
  output logic [3:0]           dmem_be,
  output logic [31:0]          dmem_wdata,
  input  logic [31:0]          dmem_rdata,
  input  logic                 dmem_ack,
  output logic [WB_BUS_W-1:0]  MEM_WB_BUS,
  output logic                 out_valid,
  output logic                 addr_err,
  output logic                 bus_err
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  through_t    th;
  logic [31:0] alu_data;
  logic [31:0] out_data;
  logic        fire;
  logic        is_mem;
  logic        unused_rsvd;

  state_e      state;
  logic [CW-1:0] cnt;
  logic        timeout_hit;
  size_e       ld_size_q;
  logic [1:0]  ld_addr_q;
  logic        ld_signed_q;
  logic        reg_write_q;
  logic [4:0]  dest_q;

  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic        misaligned;
  logic [31:0] ld_data;

  assign th          = through_t'(EXE_MEM_BUS[79:64]);
  assign alu_data    = EXE_MEM_BUS[63:32];
  assign out_data    = EXE_MEM_BUS[31:0];
  assign unused_rsvd = ^th.rsvd;

  assign in_ready    = (state == S_IDLE);
  assign fire        = in_valid && in_ready;
  assign is_mem      = th.mem_read || th.mem_write;
  // Ack has priority over this, so an ack on the last allowed cycle completes normally.
  assign timeout_hit = (TIMEOUT != 0) && ((32'(cnt) + 32'd1) == TIMEOUT);

  mem_align u_align (
    .st_size    (th.size),
    .st_addr    (alu_data[1:0]),
    .st_data    (out_data),
    .st_be      (st_be),
    .st_wdata   (st_wdata),
    .misaligned (misaligned),
    .ld_size    (ld_size_q),
    .ld_addr    (ld_addr_q),
    .ld_signed  (ld_signed_q),
    .ld_rdata   (dmem_rdata),
    .ld_data    (ld_data)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_be     <= '0;
      dmem_wdata  <= '0;
      MEM_WB_BUS  <= '0;
      out_valid   <= 1'b0;
      addr_err    <= 1'b0;
      bus_err     <= 1'b0;
      ld_size_q   <= SZ_BYTE;
      ld_addr_q   <= '0;
      ld_signed_q <= 1'b0;
      reg_write_q <= 1'b0;
      dest_q      <= '0;
    end else begin
      out_valid <= 1'b0;
      addr_err  <= 1'b0;
      bus_err   <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (fire) begin
            if (is_mem && misaligned) begin
              out_valid  <= 1'b1;
              addr_err   <= 1'b1;
              MEM_WB_BUS <= {1'b0, th.dest, 32'h0};
            end else if (is_mem) begin
              // A read+write op is a store; byte enables are only driven for stores.
              dmem_req    <= 1'b1;
              dmem_we     <= th.mem_write;
              dmem_addr   <= alu_data[31:2];
              dmem_be     <= th.mem_write ? st_be : 4'b0000;
              dmem_wdata  <= st_wdata;
              ld_size_q   <= th.size;
              ld_addr_q   <= alu_data[1:0];
              ld_signed_q <= th.signed_load;
              reg_write_q <= th.reg_write;
              dest_q      <= th.dest;
              cnt         <= '0;
              state       <= S_WAIT;
            end else begin
              out_valid  <= 1'b1;
              MEM_WB_BUS <= {th.reg_write, th.dest, out_data};
            end
          end
        end
        S_WAIT: begin
          if (dmem_ack) begin
            dmem_req   <= 1'b0;
            out_valid  <= 1'b1;
            MEM_WB_BUS <= dmem_we ? {1'b0, dest_q, 32'h0}
                                  : {reg_write_q, dest_q, ld_data};
            cnt        <= '0;
            state      <= S_IDLE;
          end else if (timeout_hit) begin
            dmem_req   <= 1'b0;
            out_valid  <= 1'b1;
            bus_err    <= 1'b1;
            MEM_WB_BUS <= {1'b0, dest_q, 32'h0};
            cnt        <= '0;
            state      <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed vectors push expected WB results;
// a monitor pops them on out_valid while a responder models data memory.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [79:0] EXE_MEM_BUS;
  logic        in_valid;
  logic        in_ready;
  logic        dmem_req, dmem_we;
  logic [29:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic [37:0] MEM_WB_BUS;
  logic        out_valid, addr_err, bus_err;

  mem_stage #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .EXE_MEM_BUS(EXE_MEM_BUS), .in_valid(in_valid),
    .in_ready(in_ready), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .MEM_WB_BUS(MEM_WB_BUS),
    .out_valid(out_valid), .addr_err(addr_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [37:0] bus;
    logic [37:0] mask;
    logic        addr_err;
    logic        bus_err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Memory responder configuration and expected request fields.
  int          ack_delay = 0;
  bit          ack_never = 1'b0;
  int          wait_cnt  = 0;
  logic [31:0] rdata_cfg = '0;
  logic        exp_we    = 1'b0;
  logic [29:0] exp_addr  = '0;
  logic [3:0]  exp_be    = '0;
  logic [31:0] exp_wdata = '0;
  bit          chk_wdata = 1'b0;
  bit          req_seen  = 1'b0;

  int lowcnt = 0, ov_count = 0, ov_run = 0, ov_run_max = 0, ov_before = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input string n, input logic rw, input logic [4:0] d,
                              input logic [31:0] w, input bit full,
                              input logic ae, input logic be_);
    exp_t e;
    e.name     = n;
    e.bus      = {rw, d, w};
    e.mask     = full ? {38{1'b1}} : 38'h20_0000_0000;
    e.addr_err = ae;
    e.bus_err  = be_;
    return e;
  endfunction

  // Monitor: compares every out_valid pulse with the oldest expectation.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      ov_count++;
      ov_run++;
      if (ov_run > ov_run_max) ov_run_max = ov_run;
      if (sb.size() == 0) begin
        check("unexpected out_valid", {63'b0, out_valid}, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, " wb_bus"}, {26'b0, MEM_WB_BUS & mon_e.mask}, {26'b0, mon_e.bus & mon_e.mask});
        check({mon_e.name, " addr_err"}, {63'b0, addr_err}, {63'b0, mon_e.addr_err});
        check({mon_e.name, " bus_err"}, {63'b0, bus_err}, {63'b0, mon_e.bus_err});
      end
    end else begin
      ov_run = 0;
      if (addr_err === 1'b1 || bus_err === 1'b1)
        check("error pulse without out_valid", {62'b0, addr_err, bus_err}, 64'd0);
    end
    if (in_ready === 1'b0 && rst === 1'b0) lowcnt++;
  end

  // Data-memory responder: checks request fields while req is held, acks after ack_delay.
  always @(negedge clk) begin
    if (rst === 1'b1 || dmem_req !== 1'b1) begin
      dmem_ack = 1'b0;
      wait_cnt = 0;
    end else begin
      req_seen = 1'b1;
      check("req addr", {34'b0, dmem_addr}, {34'b0, exp_addr});
      check("req we", {63'b0, dmem_we}, {63'b0, exp_we});
      check("req be", {60'b0, dmem_be}, {60'b0, exp_be});
      if (chk_wdata) check("req wdata", {32'b0, dmem_wdata}, {32'b0, exp_wdata});
      if (!ack_never && wait_cnt == ack_delay) begin
        dmem_ack   = 1'b1;
        dmem_rdata = rdata_cfg;
      end else begin
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
      end
      wait_cnt++;
    end
  end

  task automatic send(input logic [15:0] th, input logic [31:0] alu, input logic [31:0] od,
                      input bit push, input exp_t e);
    int n;
    EXE_MEM_BUS = {th, alu, od};
    in_valid    = 1'b1;
    n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("send in_ready wait", {63'b0, in_ready}, 64'd1);
    @(posedge clk);
    if (push) sb.push_back(e);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || in_ready !== 1'b1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("drain", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic we, input logic [29:0] a, input logic [3:0] be_,
                         input logic [31:0] wd, input bit cw);
    exp_we = we; exp_addr = a; exp_be = be_; exp_wdata = wd; chk_wdata = cw;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    EXE_MEM_BUS = '0;
    dmem_ack    = 1'b0;
    dmem_rdata  = '0;
    #12;
    check("reset in_ready", {63'b0, in_ready}, 64'd1);
    check("reset dmem_req", {63'b0, dmem_req}, 64'd0);
    check("reset out_valid", {63'b0, out_valid}, 64'd0);
    check("reset wb_bus", {26'b0, MEM_WB_BUS}, 64'd0);
    check("reset dmem fields", {dmem_we, dmem_be, dmem_addr}, 64'd0);
    check("reset errs", {62'b0, addr_err, bus_err}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Non-memory ops, including back-to-back issue and ignored reserved bits.
    ov_run_max = 0;
    send(16'h04A0, 32'h0, 32'hDEADBEEF, 1, mk("nm0", 1'b1, 5'd5, 32'hDEADBEEF, 1, 0, 0));
    send(16'h0420, 32'h0, 32'h11111111, 1, mk("nm1", 1'b1, 5'd1, 32'h11111111, 1, 0, 0));
    send(16'h0440, 32'h0, 32'h22222222, 1, mk("nm2", 1'b1, 5'd2, 32'h22222222, 1, 0, 0));
    send(16'h0460, 32'h0, 32'h33333333, 1, mk("nm3", 1'b1, 5'd3, 32'h33333333, 1, 0, 0));
    drain();
    check("b2b consecutive pulses", {63'b0, ov_run_max >= 3}, 64'd1);
    send(16'h03E0, 32'h0, 32'h0000_0001, 1, mk("nm_norw", 1'b0, 5'd31, 32'h1, 1, 0, 0));
    send(16'h04BF, 32'h0, 32'hCAFE0001, 1, mk("nm_rsvd", 1'b1, 5'd5, 32'hCAFE0001, 1, 0, 0));
    drain();

    // Signed and unsigned byte loads from lane 3, ack after 3 wait cycles.
    ack_delay = 3; rdata_cfg = 32'h80112233;
    set_req(1'b0, 30'h400, 4'b0000, 32'h0, 0);
    lowcnt = 0;
    send(16'h8CE0, 32'h1003, 32'h0, 1, mk("ldb_s", 1'b1, 5'd7, 32'hFFFFFF80, 1, 0, 0));
    drain();
    check("ldb_s stall cycles", 64'(lowcnt), 64'd4);
    send(16'h84E0, 32'h1003, 32'h0, 1, mk("ldb_u", 1'b1, 5'd7, 32'h00000080, 1, 0, 0));
    drain();

    // Signed half load from lane 2, same-cycle ack.
    ack_delay = 0; rdata_cfg = 32'h80011234;
    set_req(1'b0, 30'h8, 4'b0000, 32'h0, 0);
    send(16'h9D40, 32'h22, 32'h0, 1, mk("ldh_s", 1'b1, 5'd10, 32'hFFFF8001, 1, 0, 0));
    drain();

    // Stores: half at lane 2, byte at lane 1, read+write treated as word store.
    lowcnt = 0;
    set_req(1'b1, 30'h800, 4'b1100, 32'hABCDABCD, 1);
    send(16'h5520, 32'h2002, 32'h0000ABCD, 1, mk("sth", 1'b0, 5'd9, 32'h0, 0, 0, 0));
    drain();
    check("sth min latency stall", 64'(lowcnt), 64'd1);
    set_req(1'b1, 30'hC, 4'b0010, 32'h5A5A5A5A, 1);
    send(16'h4000, 32'h31, 32'h0000005A, 1, mk("stb", 1'b0, 5'd0, 32'h0, 0, 0, 0));
    drain();
    set_req(1'b1, 30'h4, 4'b1111, 32'hCAFEF00D, 1);
    send(16'hE400, 32'h10, 32'hCAFEF00D, 1, mk("rw_store", 1'b0, 5'd0, 32'h0, 0, 0, 0));
    drain();

    // Misaligned word load and half store: no request issued.
    req_seen = 1'b0;
    send(16'hA460, 32'h3001, 32'h0, 1, mk("mis_w", 1'b0, 5'd3, 32'h0, 0, 1, 0));
    send(16'h5400, 32'h2001, 32'h1234, 1, mk("mis_h", 1'b0, 5'd0, 32'h0, 0, 1, 0));
    drain();
    check("misaligned no dmem_req", {63'b0, req_seen}, 64'd0);

    // Timeout with no ack, then ack arriving on the final allowed cycle.
    ack_never = 1'b1;
    set_req(1'b0, 30'h1000, 4'b0000, 32'h0, 0);
    lowcnt = 0;
    send(16'hA480, 32'h4000, 32'h0, 1, mk("timeout", 1'b0, 5'd4, 32'h0, 0, 0, 1));
    drain();
    check("timeout wait cycles", 64'(lowcnt), 64'd4);
    check("timeout in_ready back", {63'b0, in_ready}, 64'd1);
    ack_never = 1'b0; ack_delay = 3; rdata_cfg = 32'h12345678;
    lowcnt = 0;
    send(16'hA480, 32'h4000, 32'h0, 1, mk("ack_last", 1'b1, 5'd4, 32'h12345678, 1, 0, 0));
    drain();
    check("ack_last wait cycles", 64'(lowcnt), 64'd4);

    // Reset during WAIT abandons the access without a write-back pulse.
    ack_never = 1'b1;
    send(16'hA480, 32'h4000, 32'h0, 0, mk("abandon", 1'b0, 5'd0, 32'h0, 0, 0, 0));
    @(posedge clk);
    check("mid-wait req high", {63'b0, dmem_req}, 64'd1);
    #3 rst = 1'b1;
    #1;
    check("async reset drops req", {63'b0, dmem_req}, 64'd0);
    check("async reset in_ready", {63'b0, in_ready}, 64'd1);
    ov_before = ov_count;
    @(negedge clk);
    rst = 1'b0;
    ack_never = 1'b0;
    repeat (5) @(negedge clk);
    check("no out_valid after abandon", 64'(ov_count), 64'(ov_before));

    drain();
    check("scoreboard empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage directly downstream of the execute stage; consumes its 80-bit result bus `{through[15:0], alu_data[31:0], out_data[31:0]}`.
- Performs loads and stores through a request/acknowledge data-memory port.
- Aligns and extends load data; produces a registered write-back bus.
- Stalls the upstream pipeline while an access is outstanding.

Parameters:
- TIMEOUT, 255, max cycles to wait for dmem_ack before flagging bus error; 0 = wait forever.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- EXE_MEM_BUS  in  80  {through, alu_data, out_data} from execute.
- in_valid  in  1  EXE_MEM_BUS holds an instruction this cycle.
- in_ready  out  1  stage accepts EXE_MEM_BUS this cycle; low = upstream stall.
- dmem_req  out  1  memory request strobe.
- dmem_we  out  1  1 = write, 0 = read.
- dmem_addr  out  30  word address = alu_data[31:2].
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_rdata  in  32  read data, valid with dmem_ack.
- dmem_ack  in  1  access complete.
- MEM_WB_BUS  out  38  {reg_write, dest[4:0], wb_data[31:0]}.
- out_valid  out  1  MEM_WB_BUS valid, one-cycle pulse per instruction.
- addr_err  out  1  misaligned access, one-cycle pulse.
- bus_err  out  1  timeout, one-cycle pulse.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: all outputs 0, except in_ready = 1; state = IDLE; counter = 0.
- `through` field layout:
  - [15] mem_read; [14] mem_write.
  - [13:12] size: 00 byte, 01 half, 10 word, 11 treated as word.
  - [11] signed_load; [10] reg_write; [9:5] dest; [4:0] reserved, ignored.
- Address is alu_data; store data is out_data; non-memory result is out_data.
- Handshake: transfer when in_valid & in_ready. in_ready = (state == IDLE).
- States:
  - IDLE, on transfer:
    - Misaligned (half with a[0]=1, word with a[1:0]≠0): no request; addr_err=1 and out_valid=1 with reg_write forced 0, next cycle; stay IDLE.
    - Non-memory op: MEM_WB_BUS = {reg_write, dest, out_data}; out_valid=1 next cycle; stay IDLE. Throughput 1/cycle, latency 1.
    - Both mem_read and mem_write set: treated as a store.
    - Memory op: latch fields; dmem_req=1 from next cycle; go to WAIT.
  - WAIT:
    - dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata held stable until ack.
    - On dmem_ack: drop req next cycle; out_valid=1 next cycle with load data (loads) or reg_write=0 (stores); go to IDLE.
    - Minimum memory-op latency = 2 cycles after transfer when ack is same-cycle with req.
  - Timeout: counter increments each WAIT cycle without ack. When TIMEOUT≠0 and counter reaches TIMEOUT: bus_err=1, out_valid=1 with reg_write=0, go IDLE, counter cleared.
  - Ack arriving on the timeout cycle: ack wins, no bus_err.
- Byte enables (a = alu_data[1:0]):
  - byte: 4'b0001 << a.
  - half: 4'b0011 << a.
  - word: 4'b1111.
- dmem_wdata: byte = {4{d[7:0]}}; half = {2{d[15:0]}}; word = d.
- Load extract: lane selected by a; sign- or zero-extend per signed_load.
- dmem_ack outside WAIT is ignored.
- rst mid-WAIT: req drops immediately; the outstanding access is abandoned; no out_valid.

Decomposition:
- Shared package (or include):
  - bus widths 80/38;
  - `through` bit positions;
  - size encodings;
  - state encoding IDLE/WAIT.
- One sub-module, mem_align: combinational be/wdata generation and load extract/extension, including the misalignment check. The stage FSM instantiates it.

Test Plan:
- Non-memory op: through reg_write=1, dest=5, out_data=32'hDEADBEEF -> next cycle out_valid=1, MEM_WB_BUS={1,5,DEADBEEF}; back-to-back 3 ops give 3 consecutive out_valid pulses.
- Signed byte load: addr=0x1003, dmem_rdata=32'h80112233, ack after 3 cycles -> dmem_addr=0x400, be=0000 on read, in_ready low 4 cycles, wb_data=FFFFFF80; unsigned variant gives 00000080.
- Half store: addr=0x2002, data=0x0000ABCD -> dmem_we=1, be=1100, wdata=ABCDABCD, out reg_write=0.
- Misaligned word load: addr=0x3001 -> no dmem_req, addr_err pulse, reg_write=0.
- Timeout: TIMEOUT=4, ack never -> bus_err after 4 WAIT cycles, in_ready returns 1; ack on cycle 4 instead -> no bus_err.
- Reset asserted during WAIT -> dmem_req=0 asynchronously, in_ready=1, no out_valid.
